// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : edge_event_arbiter
// Summary  : Synchronises NCH async inputs, qualifies rise/fall edges per
//            channel mode, holds one pending event per channel and shares a
//            single valid/ready event port through a round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module edge_event_arbiter #(
  parameter int NCH   = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   data_in,
  input  logic [2*NCH-1:0] cfg_mode,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_ch,
  output logic             evt_type,
  output logic [NCH-1:0]   overflow,
  input  logic             ovf_clr
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NCH-1:0]   r_s1;
  logic [NCH-1:0]   r_s2;
  logic [NCH-1:0]   r_s3;
  logic [NCH-1:0]   r_pend;
  logic [NCH-1:0]   r_ptype;
  logic [NCH-1:0]   r_overflow;
  logic [IDX_W-1:0] r_last;
  logic [IDX_W-1:0] r_evt_ch;
  logic             r_evt_type;

  logic [NCH-1:0]   w_rise;
  logic [NCH-1:0]   w_fall;
  logic [NCH-1:0]   w_qual;
  logic [NCH-1:0]   w_en;
  logic [NCH-1:0]   w_req;
  logic [NCH-1:0]   w_drop;
  logic [NCH-1:0]   w_grant_vec;
  logic [IDX_W-1:0] w_cand;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;
  logic             w_take;
  logic             w_grant;

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign w_rise[i] = r_s2[i] & ~r_s3[i];
      assign w_fall[i] = ~r_s2[i] & r_s3[i];
      assign w_en[i]   = |cfg_mode[2*i +: 2];
      assign w_qual[i] = (cfg_mode[2*i] & w_rise[i]) | (cfg_mode[2*i+1] & w_fall[i]);
    end
  endgenerate

  // Disabled channels are masked here so a stale pend can never be granted.
  assign w_req  = r_pend & w_en;
  assign w_drop = w_qual & r_pend & ~w_grant_vec;

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NCH; k++) begin
      w_cand = IDX_W'((int'(r_last) + k) % NCH);
      if (!w_found && w_req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_vec = '0;
    w_take      = (r_state == S_IDLE) || evt_ready;
    w_grant     = w_take && w_found;
    if (w_take) begin
      w_state_nxt = w_found ? S_HOLD : S_IDLE;
    end
    if (w_grant) begin
      w_grant_vec[w_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_s1       <= '0;
      r_s2       <= '0;
      r_s3       <= '0;
      r_pend     <= '0;
      r_ptype    <= '0;
      r_overflow <= '0;
      r_last     <= IDX_W'(NCH - 1);
      r_evt_ch   <= '0;
      r_evt_type <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_s1    <= data_in;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      if (w_grant) begin
        r_evt_ch   <= w_idx;
        r_evt_type <= r_ptype[w_idx];
        r_last     <= w_idx;
      end
      for (int i = 0; i < NCH; i++) begin
        if (!w_en[i]) begin
          r_pend[i] <= 1'b0;
        end else if (w_qual[i] && (!r_pend[i] || w_grant_vec[i])) begin
          r_pend[i]  <= 1'b1;
          r_ptype[i] <= w_rise[i];
        end else if (w_grant_vec[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
      // A new drop wins over a coincident clear.
      r_overflow <= (r_overflow & ~{NCH{ovf_clr}}) | w_drop;
    end
  end

  assign evt_valid = (r_state == S_HOLD);
  assign evt_ch    = r_evt_ch;
  assign evt_type  = r_evt_type;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_event_arbiter
// Summary  : Directed self-checking bench for edge_event_arbiter (NCH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] data_in = '0;
  logic [7:0] cfg_mode = '0;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [1:0] evt_ch;
  logic       evt_type;
  logic [3:0] overflow;
  logic       ovf_clr = 1'b0;

  int checks   = 0;
  int failures = 0;

  edge_event_arbiter #(.NCH(4), .IDX_W(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .cfg_mode (cfg_mode),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_ch   (evt_ch),
    .evt_type (evt_type),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut;
    data_in   = '0;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    cfg_mode = 8'hFF;
    rst      = 1'b1;
    for (int c = 0; c < 3; c++) begin
      data_in = 4'($urandom_range(0, 15));
      tick();
      checks++;
      if ({evt_valid, evt_ch, evt_type, overflow} !== 8'h00) begin
        failures++;
        $display("FAIL reset_outputs: got v=%b ch=%0d t=%b ovf=%b required all zero",
                 evt_valid, evt_ch, evt_type, overflow);
      end
    end
    data_in = '0;
    rst     = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (evt_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle: evt_valid=%b required 0 (cycle %0d)", evt_valid, c);
      end
    end
  endtask

  task automatic test_single_rise;
    reset_dut();
    cfg_mode  = 8'b00_00_00_01;
    evt_ready = 1'b1;
    data_in   = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (evt_valid !== 1'b0) begin
        failures++;
        $display("FAIL latency_early: evt_valid=%b required 0 at edge k+%0d", evt_valid, c);
      end
    end
    tick();
    checks++;
    if ({evt_valid, evt_ch, evt_type} !== {1'b1, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL single_rise: got v=%b ch=%0d t=%b required v=1 ch=0 t=1",
               evt_valid, evt_ch, evt_type);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_rise_one_cycle: evt_valid=%b required 0", evt_valid);
    end
    data_in = 4'b0000;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (evt_valid !== 1'b0) begin
        failures++;
        $display("FAIL fall_ignored: evt_valid=%b required 0", evt_valid);
      end
    end
  endtask

  task automatic test_stall_both;
    reset_dut();
    cfg_mode  = 8'b00_11_00_00;
    evt_ready = 1'b0;
    data_in   = 4'b0100;
    for (int c = 0; c < 5; c++) tick();
    data_in = 4'b0000;
    for (int c = 0; c < 3; c++) tick();
    checks++;
    if ({evt_valid, evt_ch, evt_type, overflow} !== {1'b1, 2'd2, 1'b1, 4'b0000}) begin
      failures++;
      $display("FAIL stall_hold: got v=%b ch=%0d t=%b ovf=%b required v=1 ch=2 t=1 ovf=0000",
               evt_valid, evt_ch, evt_type, overflow);
    end
    evt_ready = 1'b1;
    tick();
    checks++;
    if ({evt_valid, evt_ch, evt_type} !== {1'b1, 2'd2, 1'b0}) begin
      failures++;
      $display("FAIL stall_fall_next: got v=%b ch=%0d t=%b required v=1 ch=2 t=0",
               evt_valid, evt_ch, evt_type);
    end
    tick();
    checks++;
    if ({evt_valid, overflow} !== 5'b0_0000) begin
      failures++;
      $display("FAIL stall_drain: got v=%b ovf=%b required v=0 ovf=0000", evt_valid, overflow);
    end
  endtask

  task automatic test_round_robin;
    reset_dut();
    cfg_mode  = 8'b01_01_01_01;
    evt_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      data_in = 4'b1111;
      for (int c = 0; c < 3; c++) tick();
      for (int i = 0; i < 4; i++) begin
        tick();
        checks++;
        if ({evt_valid, evt_ch, evt_type} !== {1'b1, 2'(i), 1'b1}) begin
          failures++;
          $display("FAIL rr_order: burst %0d slot %0d got v=%b ch=%0d t=%b required v=1 ch=%0d t=1",
                   b, i, evt_valid, evt_ch, evt_type, i);
        end
      end
      tick();
      checks++;
      if (evt_valid !== 1'b0) begin
        failures++;
        $display("FAIL rr_end: burst %0d evt_valid=%b required 0", b, evt_valid);
      end
      data_in = 4'b0000;
      for (int c = 0; c < 4; c++) tick();
    end
  endtask

  task automatic test_overflow;
    reset_dut();
    cfg_mode  = 8'b00_00_11_00;
    evt_ready = 1'b0;
    data_in   = 4'b0010;
    tick(); tick();
    data_in = 4'b0000;
    tick(); tick();
    data_in = 4'b0010;
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if ({evt_valid, evt_ch, evt_type, overflow} !== {1'b1, 2'd1, 1'b1, 4'b0010}) begin
      failures++;
      $display("FAIL ovf_set: got v=%b ch=%0d t=%b ovf=%b required v=1 ch=1 t=1 ovf=0010",
               evt_valid, evt_ch, evt_type, overflow);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 4'b0000) begin
      failures++;
      $display("FAIL ovf_clear: overflow=%b required 0000", overflow);
    end
    data_in = 4'b0000;
    tick(); tick();
    checks++;
    if (overflow !== 4'b0000) begin
      failures++;
      $display("FAIL ovf_before_drop: overflow=%b required 0000", overflow);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if ({overflow, evt_valid, evt_ch, evt_type} !== {4'b0010, 1'b1, 2'd1, 1'b1}) begin
      failures++;
      $display("FAIL ovf_set_wins: got ovf=%b v=%b ch=%0d t=%b required ovf=0010 v=1 ch=1 t=1",
               overflow, evt_valid, evt_ch, evt_type);
    end
  endtask

  task automatic test_mid_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({evt_valid, evt_ch, evt_type, overflow} !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset: got v=%b ch=%0d t=%b ovf=%b required all zero",
               evt_valid, evt_ch, evt_type, overflow);
    end
    evt_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_discard: evt_valid=%b required 0", evt_valid);
    end
  endtask

  task automatic test_disable;
    reset_dut();
    cfg_mode  = 8'b01_00_00_01;
    evt_ready = 1'b0;
    data_in   = 4'b1001;
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if ({evt_valid, evt_ch, evt_type} !== {1'b1, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL disable_first: got v=%b ch=%0d t=%b required v=1 ch=0 t=1",
               evt_valid, evt_ch, evt_type);
    end
    cfg_mode = 8'b00_00_00_01;
    tick();
    evt_ready = 1'b1;
    tick();
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL disable_no_issue: got v=%b ch=%0d required v=0", evt_valid, evt_ch);
    end
    evt_ready = 1'b0;
    cfg_mode  = 8'b01_00_00_01;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (evt_valid !== 1'b0) begin
        failures++;
        $display("FAIL disable_pend_cleared: evt_valid=%b ch=%0d required 0", evt_valid, evt_ch);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_stall_both();
    test_round_robin();
    test_overflow();
    test_mid_reset();
    test_disable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
